bip_fetch_sequencer: RTL and testbench
======================================

Name: bip_fetch_sequencer

Overview:
- Fetch/issue controller for the BIP processor.
- Owns the program counter register and sequences instruction fetch from program memory.
- Hands each fetched instruction to the decoder and waits for execution to complete before fetching again.
- Detects HLT and wrap-around; sits between program memory, the PC increment path and the instruction decoder.

Parameters:
- PC_W, 11, program-counter/address width.
- INSTR_W, 16, instruction width.
- OPC_W, 5, opcode field width (instr_data[INSTR_W-1 -: OPC_W]).
- INCR, 1, PC increment per instruction (one word per instruction).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin execution from PC 0; honoured only in IDLE.
- instr_valid  in  1  program memory returns instr_data this cycle.
- instr_data  in  INSTR_W  instruction word from program memory.
- exec_done  in  1  datapath has finished the issued instruction.
- fetch_req  out  1  request memory read at pc_out.
- pc_out  out  PC_W  current program counter / fetch address.
- ir_out  out  INSTR_W  latched instruction register.
- ir_load  out  1  one-cycle pulse: ir_out holds a new instruction for the decoder.
- running  out  1  high in any state except IDLE and HALT.
- halted  out  1  HLT fetched; sticky until reset.
- pc_wrap  out  1  one-cycle pulse when the PC wraps from 2^PC_W-1 to 0.

Behaviour:
Reset:
- Asynchronous, active-high; also applies mid-operation, abandoning any fetch or execution immediately.
- While asserted: state=IDLE, pc_out=0, ir_out=0, and all 1-bit outputs are 0.

States: IDLE, FETCH, ISSUE, EXEC_WAIT, HALT. All outputs are registered.
- IDLE: start=1 -> FETCH. All other inputs are ignored.
- FETCH:
  - fetch_req=1, held until instr_valid. pc_out stays stable.
  - instr_valid with opcode==OPC_HLT (0): -> HALT. ir_out is not loaded and the PC is not incremented.
  - instr_valid with any other opcode: ir_out<=instr_data, -> ISSUE.
  - fetch_req drops in the cycle after instr_valid.
- ISSUE:
  - Lasts exactly one cycle, with ir_load=1.
  - PC<=PC+INCR, modulo 2^PC_W.
  - If the old PC was 2^PC_W-1: the PC becomes 0 and pc_wrap=1 during the following cycle.
  - -> EXEC_WAIT.
- EXEC_WAIT:
  - exec_done is sampled only in this state; an exec_done seen in any other state is ignored.
  - exec_done=1 -> FETCH.
- HALT: halted=1, running=0. start is ignored. The only exit is reset.

Timing:
- Minimum instruction period is 3 cycles: instr_valid in FETCH, ISSUE, exec_done in EXEC_WAIT.
- The updated pc_out is visible in the first EXEC_WAIT cycle.

Boundary conditions:
- start asserted outside IDLE: no effect.
- instr_valid outside FETCH: ignored.
- start and reset together: reset wins.

Optional Feature:
- Macro: BIP_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and a PAUSE state.
  - EXEC_WAIT with exec_done=1 goes to PAUSE instead of FETCH.
  - PAUSE goes to FETCH on step=1; running stays 1 in PAUSE.
  - step is ignored in every other state.
- When undefined: no step port, no PAUSE state; EXEC_WAIT goes directly to FETCH.

Decomposition:
- Shared package bip_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, ISSUE, EXEC_WAIT, HALT, PAUSE);
  - OPC_HLT=5'b00000;
  - default widths INSTR_W=16, OPC_W=5, PC_W=11.
- One natural sub-module, bip_pc_reg:
  - PC register with async reset, inc_en and wrap pulse output;
  - increments by INCR combinationally.
- FSM and IR stay in the top module.

Test Plan:
- Reset mid-EXEC_WAIT at PC=5 -> same-cycle pc_out=0, state IDLE, fetch_req=0, halted=0.
- start; memory returns 16'h0803 (opcode 1) with 2-cycle latency; exec_done one cycle after ir_load -> ir_out=16'h0803, ir_load pulses once, pc_out 0->1, next fetch_req at PC 1.
- Program {16'h0801, 16'h1002, 16'h0000} with exec_done each time -> two ir_load pulses, halted=1 with pc_out=2, fetch_req=0; a later start is ignored.
- Force PC=11'h7FF, fetch non-HLT -> pc_out=0, pc_wrap single-cycle pulse.
- exec_done held high continuously and instr_valid asserted while in IDLE -> no spurious fetch; instr_valid outside FETCH never loads ir_out.
- With BIP_SINGLE_STEP_EN: after exec_done the FSM sits in PAUSE with fetch_req=0 for 10 cycles; a step pulse -> fetch_req next cycle.

Source files
------------

// File: rtl/bip_ctrl_pkg.sv
// Shared types and default widths for the BIP fetch/issue control path.
package bip_ctrl_pkg;

  localparam int unsigned DEF_PC_W    = 11;
  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned DEF_OPC_W   = 5;

  localparam logic [DEF_OPC_W-1:0] OPC_HLT = 5'b00000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    EXEC_WAIT = 3'd3,
    HALT      = 3'd4,
    PAUSE     = 3'd5
  } state_e;

endpackage

// File: rtl/bip_pc_reg.sv
// Program counter register: advances by INCR on inc_en, flags the wrap to zero for one cycle.
module bip_pc_reg
  import bip_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = DEF_PC_W,
  parameter int unsigned INCR = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc,
  output logic            wrap
);

  localparam int unsigned SUM_W = PC_W + 1;

  logic [SUM_W-1:0] sum_c;

  // Extra carry bit signals that the increment rolled past the top address.
  assign sum_c = {1'b0, pc} + SUM_W'(INCR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= inc_en & sum_c[PC_W];
      if (inc_en) begin
        pc <= sum_c[PC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bip_fetch_sequencer.sv
// Fetch/issue controller for BIP: owns the PC and IR and sequences fetch, issue and execute.
// Optional single-step support (step input, PAUSE state) is enabled by BIP_SINGLE_STEP_EN.
module bip_fetch_sequencer
  import bip_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned OPC_W   = DEF_OPC_W,
  parameter int unsigned INCR    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               exec_done,
`ifdef BIP_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               fetch_req,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_load,
  output logic               running,
  output logic               halted,
  output logic               pc_wrap
);

  state_e state;
  state_e state_nxt;
  logic   is_hlt_c;
  logic   inc_en_c;

  assign is_hlt_c = (instr_data[INSTR_W-1 -: OPC_W] == OPC_W'(OPC_HLT));
  assign inc_en_c = (state == ISSUE);

  bip_pc_reg #(
    .PC_W (PC_W),
    .INCR (INCR)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .inc_en (inc_en_c),
    .pc     (pc_out),
    .wrap   (pc_wrap)
  );

  // Next-state decision; each input only matters in the one state that listens to it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = FETCH;
      FETCH:     if (instr_valid) state_nxt = is_hlt_c ? HALT : ISSUE;
      ISSUE:     state_nxt = EXEC_WAIT;
`ifdef BIP_SINGLE_STEP_EN
      EXEC_WAIT: if (exec_done) state_nxt = PAUSE;
      PAUSE:     if (step) state_nxt = FETCH;
`else
      EXEC_WAIT: if (exec_done) state_nxt = FETCH;
`endif
      HALT:      state_nxt = HALT;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ir_out    <= '0;
      fetch_req <= 1'b0;
      ir_load   <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_req <= (state_nxt == FETCH);
      ir_load   <= (state_nxt == ISSUE);
      running   <= (state_nxt == FETCH) || (state_nxt == ISSUE) ||
                   (state_nxt == EXEC_WAIT) || (state_nxt == PAUSE);
      halted    <= (state_nxt == HALT);
      if ((state == FETCH) && instr_valid && !is_hlt_c) begin
        ir_out <= instr_data;
      end
    end
  end

endmodule

// File: tb/tb_bip_fetch_sequencer.sv
// Bench for bip_fetch_sequencer: behavioural model checked every cycle plus directed literal pins.
module tb_bip_fetch_sequencer;

  localparam int PC_MAX = 2047;
`ifdef BIP_SINGLE_STEP_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = 16'h0;
  logic        exec_done = 1'b0;
`ifdef BIP_SINGLE_STEP_EN
  logic        step = 1'b0;
  bit          step_val = 1'b1;
`endif
  logic        fetch_req;
  logic [10:0] pc_out;
  logic [15:0] ir_out;
  logic        ir_load;
  logic        running;
  logic        halted;
  logic        pc_wrap;

  always #5 clk = ~clk;

  bip_fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .exec_done   (exec_done),
`ifdef BIP_SINGLE_STEP_EN
    .step        (step),
`endif
    .fetch_req   (fetch_req),
    .pc_out      (pc_out),
    .ir_out      (ir_out),
    .ir_load     (ir_load),
    .running     (running),
    .halted      (halted),
    .pc_wrap     (pc_wrap)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: 0 idle, 1 fetching, 2 issuing, 3 executing, 4 halted, 5 paused.
  int          m_phase = 0;
  int          m_pc = 0;
  logic [15:0] m_ir = 16'h0;
  bit          m_wrap = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_pc = 0; m_ir = 16'h0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      case (m_phase)
        0: if (start) m_phase = 1;
        1: if (instr_valid) begin
             if (instr_data[15:11] == 5'd0) m_phase = 4;
             else begin m_ir = instr_data; m_phase = 2; end
           end
        2: begin m_wrap = (m_pc == PC_MAX); m_pc = (m_pc + 1) % (PC_MAX + 1); m_phase = 3; end
        3: if (exec_done) m_phase = PAUSE_EN ? 5 : 1;
        5: begin
`ifdef BIP_SINGLE_STEP_EN
             if (step) m_phase = 1;
`endif
           end
        default: ;
      endcase
    end
    #1;
    chk("fetch_req", fetch_req, m_phase == 1);
    chk("ir_load", ir_load, m_phase == 2);
    chk("running", running, (m_phase == 1) || (m_phase == 2) || (m_phase == 3) || (m_phase == 5));
    chk("halted", halted, m_phase == 4);
    chk("pc_out", pc_out, m_pc);
    chk("ir_out", ir_out, m_ir);
    chk("pc_wrap", pc_wrap, m_wrap);
  end

  // Stimulus environment: memory responder and exec_done generator.
  logic [15:0] mem [0:2047];
  int lat = 1, done_mode = 0, fcnt = 0, ld_cnt = 0, wrap_cnt = 0;
  bit noise = 1'b0, rnd = 1'b0, ld_prev = 1'b0;

  function automatic logic [15:0] non_hlt();
    logic [4:0] op;
    op = 5'(1 + ($urandom % 31));
    return {op, 11'($urandom)};
  endfunction

  task automatic fill_mem(input int hlt_mod);
    for (int i = 0; i < 2048; i++)
      mem[i] = (hlt_mod != 0 && ($urandom % hlt_mod) == 0) ? {5'd0, 11'($urandom)} : non_hlt();
  endtask

  task automatic cycle(input int cond, input int tgt, output bit met);
    @(negedge clk);
    if (ir_load) ld_cnt++;
    if (pc_wrap) begin wrap_cnt++; chk("pc_zero_at_wrap", pc_out, 0); end
    case (cond)
      1: met = ir_load;
      2: met = fetch_req;
      3: met = halted;
      4: met = (pc_out == 11'(tgt)) && running && !fetch_req && !ir_load;
      5: met = pc_wrap;
      default: met = 1'b0;
    endcase
    if (fetch_req) begin
      fcnt++;
      if (fcnt >= lat) begin
        instr_valid = 1'b1; instr_data = mem[pc_out]; fcnt = 0;
        if (rnd) lat = 1 + $urandom % 3;
      end else begin
        instr_valid = 1'b0; instr_data = 16'($urandom);
      end
    end else begin
      fcnt = 0;
      instr_valid = noise && ($urandom % 4 == 0);
      instr_data = 16'($urandom);
    end
    case (done_mode)
      0: exec_done = ld_prev;
      1: exec_done = ($urandom % 3 == 0);
      2: exec_done = 1'b1;
      default: exec_done = 1'b0;
    endcase
    ld_prev = ir_load;
    if (rnd) start = ($urandom % 8 == 0);
`ifdef BIP_SINGLE_STEP_EN
    step = rnd ? ($urandom % 4 == 0) : step_val;
`endif
  endtask

  task automatic run_n(input int n);
    bit m;
    for (int i = 0; i < n; i++) cycle(0, 0, m);
  endtask

  task automatic run_until(input int cond, input int tgt, input int max, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) cycle(cond, tgt, hit);
    chk(name, hit, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1; run_n(1); start = 1'b0;
  endtask

  initial begin
    fill_mem(0);
    run_n(3);
    chk("rst_pc", pc_out, 0);
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_running", running, 0);
    chk("rst_ir", ir_out, 0);
    reset = 1'b0;

    // First instruction with a two-cycle memory latency.
    mem[0] = 16'h0803; lat = 2; done_mode = 0; ld_cnt = 0;
    pulse_start();
    run_until(1, 0, 20, "wait_first_ir_load");
    chk("first_ir", ir_out, 16'h0803);
    chk("first_pc_before_inc", pc_out, 0);
    run_until(2, 0, 20, "wait_second_fetch");
    chk("second_fetch_pc", pc_out, 1);
    chk("first_ir_load_count", ld_cnt, 1);

    // Reset while executing the instruction that left PC at 5.
    run_until(4, 5, 100, "wait_exec_pc5");
    reset = 1'b1;
    #1;
    chk("midrst_pc", pc_out, 0);
    chk("midrst_fetch_req", fetch_req, 0);
    chk("midrst_halted", halted, 0);
    chk("midrst_running", running, 0);
    run_n(2);
    reset = 1'b0;

    // Short program ending in HLT; a later start must not restart it.
    mem[0] = 16'h0801; mem[1] = 16'h1002; mem[2] = 16'h0000; lat = 1; ld_cnt = 0;
    pulse_start();
    run_until(3, 0, 50, "wait_halt");
    chk("halt_pc", pc_out, 2);
    chk("halt_fetch_req", fetch_req, 0);
    chk("halt_ir_load_count", ld_cnt, 2);
    chk("halt_ir", ir_out, 16'h1002);
    pulse_start();
    run_n(5);
    chk("halt_sticky", halted, 1);
    chk("halt_no_refetch", fetch_req, 0);
    chk("halt_pc_kept", pc_out, 2);

    // Idle with exec_done held and stray instr_valid: nothing may happen.
    reset = 1'b1; run_n(1); reset = 1'b0;
    noise = 1'b1; done_mode = 2;
    run_n(10);
    chk("idle_no_fetch", fetch_req, 0);
    chk("idle_ir_untouched", ir_out, 0);
    chk("idle_not_running", running, 0);

    // Run a full address space of non-HLT instructions to reach the wrap.
    fill_mem(0); done_mode = 1; wrap_cnt = 0;
    pulse_start();
    run_until(5, 0, 40000, "wait_wrap");
    chk("wrap_count", wrap_cnt, 1);
    run_n(3);
    chk("wrap_single_pulse", wrap_cnt, 1);

    // Random programs with occasional HLT, random start/step/exec_done noise.
    rnd = 1'b1;
    for (int p = 0; p < 20; p++) begin
      reset = 1'b1; run_n(1); reset = 1'b0;
      fill_mem(16);
      run_n(300);
    end
    rnd = 1'b0; start = 1'b0;

`ifdef BIP_SINGLE_STEP_EN
    // PAUSE holds until step.
    reset = 1'b1; run_n(1); reset = 1'b0;
    noise = 1'b0; done_mode = 0; lat = 1; step_val = 1'b0; fill_mem(0);
    pulse_start();
    run_until(1, 0, 20, "step_wait_ir_load");
    run_n(2);
    for (int i = 0; i < 10; i++) begin
      chk("pause_no_fetch", fetch_req, 0);
      chk("pause_running", running, 1);
      run_n(1);
    end
    step_val = 1'b1; run_n(1); step_val = 1'b0;
    chk("step_fetch", fetch_req, 1);
    run_n(3);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
